obi_sram_resp: RTL and testbench

OBI-style memory responder that terminates a core-side instruction or data port. It implements the subordinate end of the req/gnt/rvalid handshake driven by the cv32e40p wrapper. Storage is an internal word array with byte-enable writes. The block is used as a scratchpad/boot memory on the SoC interconnect, or directly on a core port in unit benches. Grant latency is programmable through wait states, and it flags out-of-range accesses with an error response.

---
 rtl/obi_sram_resp.sv | 107 ++++++++++
 tb/tb_obi_sram_resp.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_sram_resp.sv
// ---------------------------------------------------------------------------
// obi_sram_resp
//
// OBI-style subordinate memory. Terminates a core instruction or data port
// with the req/gnt/rvalid handshake. Storage is a word array with byte-enable
// writes. Grant latency is set by WaitCycles. Accesses outside the window
// [BaseAddr, BaseAddr + NumWords*4) get an error response.
//
// Ports:
//   clk_i     clock
//   rst_ni    synchronous active-low reset
//   req_i     request valid from the initiator
//   gnt_o     request accepted this cycle (combinational from req_i)
//   we_i      1 = write, 0 = read
//   be_i      byte enables, bit n covers wdata_i[8n+7:8n]
//   addr_i    byte address
//   wdata_i   write data
//   rvalid_o  response valid, exactly one cycle after the grant
//   rdata_o   read data, meaningful when rvalid_o = 1
//   err_o     error response, meaningful when rvalid_o = 1
// ---------------------------------------------------------------------------
module obi_sram_resp #(
  parameter int unsigned NumWords   = 256,
  parameter int unsigned WaitCycles = 0,
  parameter logic [31:0] BaseAddr   = 32'h1000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned IdxW       = $clog2(NumWords);
  localparam logic [31:0] MemBytes   = 32'(NumWords * 4);
  localparam logic [3:0]  WaitTarget = 4'(WaitCycles);

  logic [3:0]      wait_cnt;
  logic [31:0]     offset;
  logic            in_range;
  logic [IdxW-1:0] index;
  logic [31:0]     mem [NumWords];
  logic            rvalid_q;
  logic            err_q;
  logic [31:0]     rdata_q;

  // Address decode. Subtracting the base first means a single unsigned
  // compare catches addresses both below and above the window; the low two
  // address bits are simply dropped, so misaligned addresses are not errors.
  assign offset   = addr_i - BaseAddr;
  assign in_range = (offset < MemBytes);
  assign index    = offset[IdxW+1:2];

  // Grant is gated by rst_ni so nothing is accepted while in reset, even
  // though the counter itself only clears on the clock edge.
  assign gnt_o = req_i & (wait_cnt == WaitTarget) & rst_ni;

  // Wait counter: counts cycles a request has been held without a grant.
  // Clearing on the grant cycle makes back-to-back requests pay the full wait.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wait_cnt <= '0;
    end else if (req_i && !gnt_o) begin
      wait_cnt <= wait_cnt + 4'd1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // Storage write port. Not reset, so contents survive a reset pulse.
  always_ff @(posedge clk_i) begin
    if (gnt_o && we_i && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem[index][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Response register. Every grant yields one response on the next cycle.
  // rdata only updates on reads; writes leave the last read value visible.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= gnt_o;
      err_q    <= gnt_o & ~in_range;
      if (gnt_o && !we_i) begin
        rdata_q <= in_range ? mem[index] : 32'h0;
      end
    end
  end

  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_obi_sram_resp.sv
// ---------------------------------------------------------------------------
// tb_obi_sram_resp
//
// Three responder instances with WaitCycles = 0, 3 and 5 share one clock and
// reset. Each granted access pushes its expected response (from a small
// reference memory model) onto a scoreboard queue; a monitor pops and
// compares whenever an instance raises rvalid, including response latency.
// ---------------------------------------------------------------------------
module tb_obi_sram_resp;

  localparam int          NumInst = 3;
  localparam logic [31:0] Base    = 32'h1000_0000;

  typedef struct {
    int          inst;
    int          due;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req    [NumInst];
  logic        gnt    [NumInst];
  logic        we     [NumInst];
  logic [3:0]  be     [NumInst];
  logic [31:0] addr   [NumInst];
  logic [31:0] wdata  [NumInst];
  logic        rvalid [NumInst];
  logic [31:0] rdata  [NumInst];
  logic        err    [NumInst];

  int          check_count = 0;
  int          error_count = 0;
  int          cyc = 0;
  resp_t       exp_q[$];
  resp_t       mon_e;

  logic [31:0] model_mem   [NumInst][256];
  logic [31:0] model_rdata [NumInst];

  logic        hold_pend [NumInst];
  logic [68:0] hold_snap [NumInst];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NumInst; g++) begin : g_dut
    obi_sram_resp #(
      .NumWords  (256),
      .WaitCycles((g == 0) ? 0 : (g == 1) ? 3 : 5),
      .BaseAddr  (Base)
    ) u_dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .req_i   (req[g]),
      .gnt_o   (gnt[g]),
      .we_i    (we[g]),
      .be_i    (be[g]),
      .addr_i  (addr[g]),
      .wdata_i (wdata[g]),
      .rvalid_o(rvalid[g]),
      .rdata_o (rdata[g]),
      .err_o   (err[g])
    );
  end

  function automatic int wait_of(input int g);
    case (g)
      0:       return 0;
      1:       return 3;
      default: return 5;
    endcase
  endfunction

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Reference model of one granted access; returns the response to expect.
  task automatic modelGrant(input int g);
    resp_t       e;
    logic [31:0] off;
    logic [7:0]  idx;
    off     = addr[g] - Base;
    idx     = off[9:2];
    e.inst  = g;
    e.due   = cyc + 1;
    e.err   = 1'b0;
    if (off >= 32'd1024) begin
      e.err = 1'b1;
      if (!we[g]) model_rdata[g] = 32'h0;
    end else if (we[g]) begin
      for (int b = 0; b < 4; b++)
        if (be[g][b]) model_mem[g][idx][8*b +: 8] = wdata[g][8*b +: 8];
    end else begin
      model_rdata[g] = model_mem[g][idx];
    end
    e.rdata = model_rdata[g];
    exp_q.push_back(e);
  endtask

  // Drive one request on instance g and hold it until granted. Called and
  // returns at posedge+1; req is left high so calls can run back-to-back.
  task automatic applyStimulus(input int g, input logic w, input logic [3:0] b,
                               input logic [31:0] a, input logic [31:0] d);
    int waits;
    bit granted;
    waits    = 0;
    granted  = 0;
    req[g]   = 1'b1;
    we[g]    = w;
    be[g]    = b;
    addr[g]  = a;
    wdata[g] = d;
    for (int c = 0; c < 40 && !granted; c++) begin
      @(negedge clk);
      if (gnt[g] === 1'b1) begin
        granted = 1;
        modelGrant(g);
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    if (!granted) begin
      checkOutput("gnt_timeout", 32'(gnt[g]), 32'd1);
      req[g] = 1'b0;
    end else begin
      checkOutput("wait_cycles", waits, wait_of(g));
    end
  endtask

  task automatic idleCycles(input int g, input int n);
    req[g] = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: pops an expected response whenever rvalid is seen
  // and flags responses that never arrived by their due cycle.
  always @(negedge clk) begin
    for (int g = 0; g < NumInst; g++) begin
      if (rvalid[g] === 1'b1) begin
        if (exp_q.size() == 0) begin
          checkOutput("rvalid_unexpected", 32'(rvalid[g]), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("resp_inst", g, mon_e.inst);
          checkOutput("resp_latency", cyc, mon_e.due);
          checkOutput("rdata", rdata[g], mon_e.rdata);
          checkOutput("err", 32'(err[g]), 32'(mon_e.err));
        end
      end else if (rst_n === 1'b1) begin
        checkOutput("err_idle", 32'(err[g]), 32'd0);
      end
    end
    if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      mon_e = exp_q.pop_front();
      checkOutput("rvalid_missing", 32'(rvalid[mon_e.inst]), 32'd1);
    end
  end

  // Initiator obligation: request fields stay stable while waiting for gnt.
  always @(negedge clk) begin
    for (int g = 0; g < NumInst; g++) begin
      if (hold_pend[g] && req[g] === 1'b1) begin
        assert ({we[g], be[g], addr[g], wdata[g]} == hold_snap[g])
          else $error("[TB] initiator changed request fields while waiting, inst %0d", g);
      end
      hold_pend[g] = rst_n && req[g] && !gnt[g];
      hold_snap[g] = {we[g], be[g], addr[g], wdata[g]};
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    for (int g = 0; g < NumInst; g++) begin
      req[g]         = 1'b0;
      we[g]          = 1'b0;
      be[g]          = 4'h0;
      addr[g]        = Base;
      wdata[g]       = 32'h0;
      model_rdata[g] = 32'h0;
      hold_pend[g]   = 1'b0;
      hold_snap[g]   = '0;
    end

    // Reset held three cycles with a request pending on the zero-wait port.
    @(posedge clk);
    #1;
    req[0] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      for (int g = 0; g < NumInst; g++) begin
        checkOutput("rst_gnt", 32'(gnt[g]), 32'd0);
        checkOutput("rst_rvalid", 32'(rvalid[g]), 32'd0);
        checkOutput("rst_err", 32'(err[g]), 32'd0);
        checkOutput("rst_rdata", rdata[g], 32'h0);
      end
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;

    // Zero-wait write then back-to-back read; grant in first cycle out of reset.
    applyStimulus(0, 1'b1, 4'hF, 32'h1000_0010, 32'hDEAD_BEEF);
    applyStimulus(0, 1'b0, 4'hF, 32'h1000_0010, 32'h0);

    // Byte enables, including an all-zero mask, plus a misaligned read.
    applyStimulus(0, 1'b1, 4'hF,    32'h1000_0020, 32'h1122_3344);
    applyStimulus(0, 1'b1, 4'b0101, 32'h1000_0020, 32'hAABB_CCDD);
    applyStimulus(0, 1'b0, 4'hF,    32'h1000_0020, 32'h0);
    applyStimulus(0, 1'b1, 4'h0,    32'h1000_0020, 32'hFFFF_FFFF);
    applyStimulus(0, 1'b0, 4'hF,    32'h1000_0020, 32'h0);
    applyStimulus(0, 1'b0, 4'hF,    32'h1000_0013, 32'h0);

    // Out-of-range above and below the window; word 255 must be untouched.
    applyStimulus(0, 1'b1, 4'hF, 32'h1000_03FC, 32'hCAFE_F00D);
    applyStimulus(0, 1'b0, 4'hF, 32'h1000_0400, 32'h0);
    applyStimulus(0, 1'b1, 4'hF, 32'h0FFF_FFFC, 32'h5555_5555);
    applyStimulus(0, 1'b0, 4'hF, 32'h1000_03FC, 32'h0);
    idleCycles(0, 2);

    // Three wait states with req held continuously across two requests.
    applyStimulus(1, 1'b1, 4'hF, 32'h1000_0040, 32'h0BAD_C0DE);
    applyStimulus(1, 1'b0, 4'hF, 32'h1000_0040, 32'h0);
    idleCycles(1, 2);

    // Request dropped before grant: nothing recorded, counter restarts.
    req[1]  = 1'b1;
    we[1]   = 1'b1;
    be[1]   = 4'hF;
    addr[1] = 32'h1000_0040;
    wdata[1] = 32'h7777_7777;
    repeat (2) begin
      @(negedge clk);
      checkOutput("drop_gnt", 32'(gnt[1]), 32'd0);
      @(posedge clk);
      #1;
    end
    idleCycles(1, 1);
    applyStimulus(1, 1'b0, 4'hF, 32'h1000_0040, 32'h0);
    idleCycles(1, 2);

    // Five wait states: store a word, then reset two cycles into a wait.
    applyStimulus(2, 1'b1, 4'hF, 32'h1000_0014, 32'h1234_5678);
    idleCycles(2, 1);
    req[2]  = 1'b1;
    we[2]   = 1'b0;
    addr[2] = 32'h1000_0014;
    repeat (2) begin
      @(negedge clk);
      checkOutput("midwait_gnt", 32'(gnt[2]), 32'd0);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checkOutput("midrst_gnt", 32'(gnt[2]), 32'd0);
      checkOutput("midrst_rvalid", 32'(rvalid[2]), 32'd0);
      @(posedge clk);
      #1;
    end
    for (int g = 0; g < NumInst; g++) model_rdata[g] = 32'h0;
    rst_n = 1'b1;
    applyStimulus(2, 1'b0, 4'hF, 32'h1000_0014, 32'h0);
    idleCycles(2, 4);

    checkOutput("queue_drain", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
